// File: rtl/flit_input_fifo_pkg.sv
// Shared flit field layout, flit-id encodings and packet-tracking state type
// for the router input-port buffer.
package flit_input_fifo_pkg;

  localparam int ID_MSB  = 31;
  localparam int ID_LSB  = 29;
  localparam int DST_MSB = 28;
  localparam int DST_LSB = 25;
  localparam int SRC_MSB = 24;
  localparam int SRC_LSB = 21;

  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  typedef enum logic {
    PKT_IDLE,
    PKT_IN
  } pkt_state_e;

endpackage

// File: rtl/flit_input_fifo_if.sv
// Handshake and status bundle between the upstream link/downstream allocator
// and the input FIFO.
interface flit_input_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] flit_out;
  logic [2:0]            flit_id;
  logic [3:0]            dst_addr;
  logic                  empty;
  logic                  full;
  logic [PTR_W:0]        count;
  logic                  overflow;
  logic                  underflow;
  logic                  proto_err;

  modport master (
    output wr_en, flit_in, rd_en,
    input  flit_out, flit_id, dst_addr, empty, full, count,
           overflow, underflow, proto_err
  );

  modport slave (
    input  wr_en, flit_in, rd_en,
    output flit_out, flit_id, dst_addr, empty, full, count,
           overflow, underflow, proto_err
  );

endinterface

// File: rtl/flit_input_fifo_mem.sv
// Flit storage: register array with a synchronous write port and an
// asynchronous read port (first-word-fall-through head).
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flit_input_fifo.sv
// Router input-port flit FIFO: FWFT head with LBDR-ready flit_id/dst_addr decode,
// write-side packet framing check and sticky misuse flags.
module flit_input_fifo
  import flit_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  flit_input_fifo_if.slave fif
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [3:0]            pkt_dst_q, pkt_dst_d;
  logic                  overflow_q, underflow_q, proto_err_q;
  pkt_state_e            state_q;
  logic                  empty, full, do_wr, do_rd;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            head_id, in_id;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_wr   = fif.wr_en && !full;
  assign do_rd   = fif.rd_en && !empty;
  assign head_id = head[ID_MSB:ID_LSB];
  assign in_id   = fif.flit_in[ID_MSB:ID_LSB];

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (fif.flit_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_dst_d = pkt_dst_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // Latch the packet destination as its header leaves, so body flits route alike.
    if (do_rd && head_id == FLIT_HEADER) pkt_dst_d = head[DST_MSB:DST_LSB];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_dst_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_dst_q   <= pkt_dst_d;
      overflow_q  <= overflow_q  | (fif.wr_en && full);
      underflow_q <= underflow_q | (fif.rd_en && empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= PKT_IDLE;
      proto_err_q <= 1'b0;
    end else if (do_wr) begin
      case (state_q)
        PKT_IDLE: begin
          if (in_id == FLIT_HEADER) state_q <= PKT_IN;
          else proto_err_q <= 1'b1;
        end
        default: begin
          // A repeated header restarts the packet; illegal ids keep the packet open.
          case (in_id)
            FLIT_PAYLOAD: state_q <= PKT_IN;
            FLIT_TAIL:    state_q <= PKT_IDLE;
            default:      proto_err_q <= 1'b1;
          endcase
        end
      endcase
    end
  end

  assign fif.flit_out  = head;
  assign fif.flit_id   = empty ? 3'b000 : head_id;
  assign fif.dst_addr  = empty ? 4'd0 :
                         (head_id == FLIT_HEADER) ? head[DST_MSB:DST_LSB] : pkt_dst_q;
  assign fif.empty     = empty;
  assign fif.full      = full;
  assign fif.count     = count_q;
  assign fif.overflow  = overflow_q;
  assign fif.underflow = underflow_q;
  assign fif.proto_err = proto_err_q;

endmodule

// File: tb/tb_flit_input_fifo.sv
// Directed plus randomized check of flit_input_fifo against a queue-based
// packet/FIFO model.
module tb_flit_input_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flit_input_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  flit_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .fif (bus)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [31:0] mq[$];
  logic [3:0]  m_pkt_dst = 4'd0;
  bit          m_in_pkt = 1'b0;
  bit          m_ovf = 1'b0, m_udf = 1'b0, m_perr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy is a queue, framing is "are we inside a packet".
  always @(posedge clk) begin
    logic [31:0] h;
    logic [2:0]  id;
    bit was_full, was_empty;
    if (!rst) begin
      mq.delete();
      m_pkt_dst = 4'd0; m_in_pkt = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0; m_perr = 1'b0;
    end else begin
      was_full  = (mq.size() == 4);
      was_empty = (mq.size() == 0);
      if (bus.wr_en && was_full)  m_ovf = 1'b1;
      if (bus.rd_en && was_empty) m_udf = 1'b1;
      if (bus.rd_en && !was_empty) begin
        h = mq.pop_front();
        if (h[31:29] == 3'b001) m_pkt_dst = h[28:25];
      end
      if (bus.wr_en && !was_full) begin
        mq.push_back(bus.flit_in);
        id = bus.flit_in[31:29];
        if (!m_in_pkt) begin
          if (id == 3'b001) m_in_pkt = 1'b1; else m_perr = 1'b1;
        end else begin
          if (id == 3'b100) m_in_pkt = 1'b0;
          else if (id != 3'b010) m_perr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] h;
    logic [2:0]  eid;
    logic [3:0]  edst;
    if (check_en) begin
      h    = (mq.size() != 0) ? mq[0] : 32'h0;
      eid  = (mq.size() != 0) ? h[31:29] : 3'b000;
      edst = (mq.size() == 0) ? 4'd0 : (eid == 3'b001) ? h[28:25] : m_pkt_dst;
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.full), 32'(mq.size() == 4));
      chk("flit_id", 32'(bus.flit_id), 32'(eid));
      chk("dst_addr", 32'(bus.dst_addr), 32'(edst));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_udf));
      chk("proto_err", 32'(bus.proto_err), 32'(m_perr));
      if (mq.size() != 0) chk("flit_out", bus.flit_out, h);
    end
  end

  task automatic cyc(input logic w, input logic [31:0] f, input logic r);
    bus.wr_en = w; bus.flit_in = f; bus.rd_en = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] f;
    logic [2:0]  id;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flit_in = '0;
    rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    check_en = 1'b1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_dst", 32'(bus.dst_addr), 32'd0);

    // Single header, dst 5
    cyc(1'b1, 32'h2A00_0000, 1'b0);
    chk("t1_empty", 32'(bus.empty), 32'd0);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_id", 32'(bus.flit_id), 32'd1);
    chk("t1_dst", 32'(bus.dst_addr), 32'd5);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_pop_empty", 32'(bus.empty), 32'd1);
    cyc(1'b1, 32'h4000_0011, 1'b0);
    chk("t1_pkt_dst", 32'(bus.dst_addr), 32'd5);
    cyc(1'b1, 32'h8000_0022, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_perr", 32'(bus.proto_err), 32'd0);

    // H(dst 9), P, T
    cyc(1'b1, 32'h3200_0033, 1'b0);
    cyc(1'b1, 32'h4000_0044, 1'b0);
    cyc(1'b1, 32'h8000_0055, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_dst", 32'(bus.dst_addr), 32'd9);
      cyc(1'b0, 32'h0, 1'b1);
    end
    chk("t2_perr", 32'(bus.proto_err), 32'd0);
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // Five writes into four slots
    cyc(1'b1, 32'h2600_0001, 1'b0);
    for (int i = 2; i <= 4; i++) cyc(1'b1, 32'h4000_0000 + 32'(i), 1'b0);
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_ovf_pre", 32'(bus.overflow), 32'd0);
    cyc(1'b1, 32'h4000_0005, 1'b0);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    chk("t3_count", 32'(bus.count), 32'd4);
    chk("t3_head0", bus.flit_out, 32'h2600_0001);
    chk("t3_dst0", 32'(bus.dst_addr), 32'd3);
    cyc(1'b0, 32'h0, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      chk("t3_head", bus.flit_out, 32'h4000_0000 + 32'(i));
      chk("t3_dst", 32'(bus.dst_addr), 32'd3);
      cyc(1'b0, 32'h0, 1'b1);
    end
    chk("t3_drained", 32'(bus.empty), 32'd1);

    // Simultaneous write/read at full, then at empty
    do_reset();
    cyc(1'b1, 32'h2800_0010, 1'b0);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 32'h4000_0010 + 32'(i), 1'b0);
    cyc(1'b1, 32'h8000_0099, 1'b1);
    chk("t4_count3", 32'(bus.count), 32'd3);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    chk("t4_head", bus.flit_out, 32'h4000_0011);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1);
    chk("t4_udf_pre", 32'(bus.underflow), 32'd0);
    cyc(1'b1, 32'h8000_0077, 1'b1);
    chk("t4_udf", 32'(bus.underflow), 32'd1);
    chk("t4_count1", 32'(bus.count), 32'd1);
    chk("t4_late", bus.flit_out, 32'h8000_0077);
    chk("t4_dst", 32'(bus.dst_addr), 32'd4);
    cyc(1'b0, 32'h0, 1'b1);

    // Framing violations do not block delivery
    do_reset();
    cyc(1'b1, 32'h4000_00A1, 1'b0);
    chk("t5_perr", 32'(bus.proto_err), 32'd1);
    cyc(1'b1, 32'h2200_00A2, 1'b0);
    cyc(1'b1, 32'h2400_00A3, 1'b0);
    chk("t5_h0", bus.flit_out, 32'h4000_00A1);
    chk("t5_dst_none", 32'(bus.dst_addr), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t5_h1", bus.flit_out, 32'h2200_00A2);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t5_h2", bus.flit_out, 32'h2400_00A3);
    chk("t5_dst2", 32'(bus.dst_addr), 32'd2);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t5_perr_sticky", 32'(bus.proto_err), 32'd1);

    // Reset mid-packet
    cyc(1'b1, 32'h2A00_0001, 1'b0);
    cyc(1'b1, 32'h4000_0002, 1'b0);
    cyc(1'b1, 32'h4000_0003, 1'b0);
    do_reset();
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_flags", {29'd0, bus.overflow, bus.underflow, bus.proto_err}, 32'd0);
    chk("t6_dst", 32'(bus.dst_addr), 32'd0);
    cyc(1'b1, 32'h2A00_0002, 1'b0);
    chk("t6_id", 32'(bus.flit_id), 32'd1);
    chk("t6_hdst", 32'(bus.dst_addr), 32'd5);
    chk("t6_perr", 32'(bus.proto_err), 32'd0);

    // Random traffic, mostly well-formed ids with occasional illegal ones
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: id = 3'b001;
        3, 4, 5: id = 3'b010;
        6, 7, 8: id = 3'b100;
        default: id = 3'($urandom);
      endcase
      f = {id, 29'($urandom)};
      rst = ($urandom_range(0, 199) != 0);
      cyc(1'($urandom_range(0, 2) != 0), f, 1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);

    @(negedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flit_input_fifo.md
Name: flit_input_fifo

Overview:
Per-port input buffer that sits directly upstream of the minimal LBDR routing stage in each router input port. It stores incoming 32-bit flits and presents the head flit first-word-fall-through. It decodes flit_id and dst_addr exactly as the routing stage consumes them, and drives its empty input. A small packet-tracking FSM flags framing violations; sticky overflow and underflow flags report handshake misuse.

Parameters:
DATA_WIDTH, 32, flit width in bits.
DEPTH, 4, number of flit slots; must be a power of two, minimum 2.
PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low; rst==0 at a rising edge resets all state.
wr_en  in  1  upstream write strobe; flit_in is captured when wr_en && !full.
flit_in  in  DATA_WIDTH  incoming flit. [31:29]=flit_id, [28:25]=dst_addr (header only), [24:21]=src_addr (header only), rest payload.
rd_en  in  1  downstream pop strobe (from the allocator after LBDR routing); pops when rd_en && !empty.
flit_out  out  DATA_WIDTH  head flit; valid when !empty.
flit_id  out  3  flit_out[31:29] when !empty, else 3'b000.
dst_addr  out  4  header head: flit_out[28:25]; non-header head: pkt_dst register; empty: 4'd0.
empty  out  1  FIFO holds no flits.
full  out  1  count==DEPTH.
count  out  PTR_W+1  current occupancy.
overflow  out  1  sticky; set on wr_en && full.
underflow  out  1  sticky; set on rd_en && empty.
proto_err  out  1  sticky; set on a packet framing violation at write side.

Behaviour:
- Reset (rst==0): rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=underflow=proto_err=0, pkt_dst=0, FSM=IDLE. Memory contents are not reset. flit_out is don't-care but flit_id=0 and dst_addr=0 because empty=1. Reset mid-packet discards all stored flits. No reset override in the same cycle.
- Write: when wr_en && !full, mem[wr_ptr]<=flit_in and wr_ptr increments, wrapping modulo DEPTH.
- Read: when rd_en && !empty, rd_ptr increments, wrapping modulo DEPTH.
- Count: count+1 on write only; count-1 on read only; unchanged on simultaneous write and read.
- Full + simultaneous wr_en/rd_en: the write is rejected (full is evaluated pre-edge), the read proceeds, overflow is set.
- Empty + simultaneous wr_en/rd_en: the read is ignored, underflow is set, the write proceeds. The flit becomes visible next cycle.
- Latency: a flit written at edge N gives empty=0 and valid flit_out/flit_id/dst_addr after edge N. empty and full are derived from registered count.
- pkt_dst: on a pop of a HEADER flit, pkt_dst<=flit_out[28:25]. PAYLOAD and TAIL heads report pkt_dst. The routing stage then sees a stable destination for the whole packet.
- Flit ids (`HEADER 3'b001, `PAYLOAD 3'b010, `TAIL 3'b100) are taken from parameters.sv. Any other id is illegal.
- Packet FSM: advances only on accepted writes; it has two states.
  - IDLE: HEADER -> IN_PKT. PAYLOAD, TAIL or illegal id -> proto_err=1, stay IDLE.
  - IN_PKT: PAYLOAD -> stay. TAIL -> IDLE. HEADER or illegal id -> proto_err=1. A HEADER restarts the packet and stays IN_PKT; an illegal id stays IN_PKT.
- The FIFO stores and delivers every accepted flit regardless of proto_err. Rejected (overflow) writes do not advance the FSM.
- Sticky flags clear only on reset.

Decomposition:
- Flit field positions (ID_MSB/LSB, DST_MSB/LSB, SRC_MSB/LSB) and the HEADER/PAYLOAD/TAIL encodings go in the shared parameters.sv include.
- Add a typedef for the packet FSM state (IDLE, IN_PKT) there.
- Use one natural sub-module, fifo_mem, for storage. It has a DEPTH x DATA_WIDTH register array, a synchronous write port and an asynchronous read port. Pointers, count, flags and the FSM stay in the top.

Test Plan:
- Write one flit 0x2A00_0000 (id HEADER, dst 5), no reads.
  -> Next cycle empty=0, count=1, flit_id=3'b001, dst_addr=4'd5. Pop -> empty=1, pkt_dst=5.
- Write HEADER(dst 9), PAYLOAD, TAIL, then pop all three.
  -> dst_addr=9 on all three heads, proto_err=0, FSM returns to IDLE.
- Write 5 flits with DEPTH=4 and no reads.
  -> full=1 after the 4th write; 5th write dropped; overflow=1; count=4. Reads return the first 4 in order, with pointer wrap verified.
- At full, assert wr_en and rd_en together.
  -> count stays 4 then drops to 3. Overflow set, one flit popped. At empty, same stimulus -> underflow=1, count=1.
- Write PAYLOAD with the FSM in IDLE, then HEADER, HEADER.
  -> proto_err=1 after the first write and remains 1. All 3 flits are still delivered in order.
- Fill 3 flits, then drive rst=0 for one cycle mid-packet.
  -> empty=1, count=0, all flags 0, dst_addr=0. A subsequent HEADER is accepted cleanly.
